cpu_core_param: RTL and testbench
=================================

# cpu_core_param

Parametrised multi-cycle accumulator CPU core: next generation of the 16-bit CPU, generalised in data width and general-register count, with a real memory wait-state handshake, working IN/OUT handshakes, stack PUSH/POP, conditional branches and an illegal-opcode trap. It sits between the system memory/IO fabric and the top-level start/finish control, and replaces the fixed X/Y register pair and the separate ALU start/finish protocol with an internal single-cycle ALU and an NREGS-entry register file.

## Interface
- WIDTH, 16, data/address/instruction width; legal range is 16 or more.
- NREGS, 2, number of general registers; power of 2 from 2 to 8; RB = log2(NREGS).
- SP_INIT, 512, stack pointer value after reset and after every start.
- clk  in  1  clock; all state changes on the rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled in IDLE or HALT.
- finish  out  1  high while in HALT.
- err  out  1  high in HALT when the halt was caused by an illegal opcode.
- flags  out  4  {N,Z,C,V}.
- address  out  WIDTH  memory address.
- mem_out  out  WIDTH  write data.
- mem_in  in  WIDTH  read data; valid in the cycle mem_ack is high.
- read, write  out  1  memory request, at most one high at a time.
- mem_ack  in  1  completes the current read or write.
- inp_req  out  1, inp_ack  in  1, inp_data  in  WIDTH  input handshake.
- out_req  out  1, out_ack  in  1, out_data  out  WIDTH  output handshake.

## Operation
- Instruction fields:
  - op = ir[WIDTH-1 -: 6]
  - r = ir[WIDTH-7 -: RB]
  - imm = ir[WIDTH-7-RB:0], IW bits
  - sx = sign-extended imm; zx = zero-extended imm
- Opcodes:
  - 0 HLT.
  - 1 LDI: R[r] = sx.
  - 2 LD: R[r] = mem[zx].
  - 3 ST: mem[zx] = R[r].
  - 4 MOVA: AC = R[r].
  - 5 MOVR: R[r] = AC.
  - 6 ADD, 7 SUB, 8 AND, 9 OR: AC = AC op R[r]; these four are the only instructions that update flags.
  - 10 PUSH: SP = SP-1, then mem[SP] = R[r].
  - 11 POP: R[r] = mem[SP], then SP = SP+1.
  - 12 JMP: PC = zx.
  - 13 BZ: PC = zx if Z is set.
  - 14 BN: PC = zx if N is set.
  - 15 IN: R[r] = inp_data.
  - 16 OUT: out_data = R[r].
  - 17 NOP.
  - Every other opcode is illegal: go to HALT and set err.
- Flags:
  - N = result MSB; Z = result is 0.
  - C = carry out for ADD; borrow-free (AC >= R) for SUB; 0 for AND and OR.
  - V = signed overflow for ADD and SUB; 0 for AND and OR.
- State machine:
  - IDLE: on start go to FETCH; PC=0, SP=SP_INIT, flags=0, err=0.
  - FETCH: read=1, address=PC. On mem_ack: IR = mem_in, PC = PC+1, go to EXEC.
  - EXEC:
    - Register, ALU, jump, branch and NOP instructions complete here and go to FETCH.
    - LD, ST, PUSH, POP go to MEM.
    - IN goes to IO_IN; OUT goes to IO_OUT.
    - HLT and illegal opcodes go to HALT.
  - MEM: read or write held, with address and mem_out stable, until mem_ack; then go to FETCH. SP is updated in the mem_ack cycle.
  - IO_IN: inp_req=1 until inp_ack; R[r] captures inp_data on the ack edge.
  - IO_OUT: out_req=1 and out_data=R[r] until out_ack.
  - HALT: finish=1. On start, reinitialise as in IDLE and go to FETCH; registers R and AC keep their values.
- Arithmetic is modulo 2^WIDTH. PC and SP wrap silently; there is no stack overflow or underflow detection.
- start is ignored outside IDLE and HALT.

## Timing
- Reset: state = IDLE; PC = 0; SP = SP_INIT; AC = 0; every R = 0; flags = 0; IR = 0.
- All outputs are 0 during and after reset: finish, err, read, write, inp_req, out_req, address, mem_out, out_data.
- All outputs are registered or decoded from state only. There is no combinational path from any ack to any req.
- A req stays high through the cycle in which its ack is sampled and drops in the next cycle.
- An ack arriving while no req is pending is ignored.
- Latency with ack in the first request cycle:
  - Register, ALU, branch and NOP instructions: 2 cycles.
  - Memory and IO instructions: 3 cycles.
  - Each wait cycle adds 1.
- Reset asserted mid-transaction drops all requests immediately (asynchronous). No partial register or SP update is committed.

## Structure
- Package cpu_core_pkg holds:
  - opcode localparams;
  - the state enum {IDLE, FETCH, EXEC, MEM, IO_IN, IO_OUT, HALT};
  - the flag bit indices.
- Sub-module cpu_regfile: NREGS x WIDTH, one combinational read port, one synchronous write port, async clear on rst_b.
- The ALU is inline combinational logic in the core.

## Test plan
- Reset, then start with mem[0]=LDI r0,5; mem[1]=LDI r1,3; mem[2]=MOVA r0; mem[3]=SUB r1; mem[4]=HLT. Required:
  - AC = 2, flags = 0010, finish = 1 after 10 cycles.
- Memory returns mem_ack 3 cycles late on every access:
  - read is held stable for 4 cycles per access;
  - results are identical to the zero-wait case.
- PUSH r0 then POP r1 with r0 = 16'hBEEF:
  - the write goes to address 511;
  - r1 = 16'hBEEF;
  - SP returns to 512.
- ADD with AC = 16'h7FFF and R = 1: flags N=1, Z=0, C=0, V=1. A following BN to address 40 loads PC = 40.
- IN with inp_ack delayed 2 cycles and inp_data = 16'h1234: R = 16'h1234. OUT holds out_req with out_data stable until out_ack.
- Opcode 63 fetched: finish = 1 and err = 1. A new start clears err, and asserting rst_b low mid-FETCH clears read within the same cycle.

Source files
------------

// File: rtl/cpu_core_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the accumulator core.
package cpu_core_pkg;

    localparam logic [5:0] OP_HLT  = 6'd0;
    localparam logic [5:0] OP_LDI  = 6'd1;
    localparam logic [5:0] OP_LD   = 6'd2;
    localparam logic [5:0] OP_ST   = 6'd3;
    localparam logic [5:0] OP_MOVA = 6'd4;
    localparam logic [5:0] OP_MOVR = 6'd5;
    localparam logic [5:0] OP_ADD  = 6'd6;
    localparam logic [5:0] OP_SUB  = 6'd7;
    localparam logic [5:0] OP_AND  = 6'd8;
    localparam logic [5:0] OP_OR   = 6'd9;
    localparam logic [5:0] OP_PUSH = 6'd10;
    localparam logic [5:0] OP_POP  = 6'd11;
    localparam logic [5:0] OP_JMP  = 6'd12;
    localparam logic [5:0] OP_BZ   = 6'd13;
    localparam logic [5:0] OP_BN   = 6'd14;
    localparam logic [5:0] OP_IN   = 6'd15;
    localparam logic [5:0] OP_OUT  = 6'd16;
    localparam logic [5:0] OP_NOP  = 6'd17;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEM,
        IO_IN,
        IO_OUT,
        HALT
    } state_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cpu_regfile.sv
// General register file: combinational read, synchronous write, async clear.
module cpu_regfile #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 2
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic [$clog2(NREGS)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata
);

    logic [WIDTH-1:0] regs [NREGS];

    assign rdata = regs[raddr];

    // Register storage with asynchronous clear
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            regs <= '{default: '0};
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/cpu_core_param.sv
// Multi-cycle accumulator CPU with register file, stack, IO handshakes and trap.
module cpu_core_param
    import cpu_core_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NREGS   = 2,
    parameter int unsigned SP_INIT = 512
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    output logic             finish,
    output logic             err,
    output logic [3:0]       flags,
    output logic [WIDTH-1:0] address,
    output logic [WIDTH-1:0] mem_out,
    input  logic [WIDTH-1:0] mem_in,
    output logic             read,
    output logic             write,
    input  logic             mem_ack,
    output logic             inp_req,
    input  logic             inp_ack,
    input  logic [WIDTH-1:0] inp_data,
    output logic             out_req,
    input  logic             out_ack,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned RB = $clog2(NREGS);
    localparam int unsigned IW = WIDTH - 6 - RB;

    state_t           state, state_nx;
    logic [WIDTH-1:0] pc, pc_nx, sp, sp_nx, ac, ac_nx, ir, ir_nx;
    logic [3:0]       flags_nx;
    logic             err_nx, finish_nx, read_nx, write_nx, inp_req_nx, out_req_nx;
    logic [WIDTH-1:0] address_nx, mem_out_nx, out_data_nx;

    logic [5:0]       op;
    logic [RB-1:0]    r;
    logic [IW-1:0]    imm;
    logic [WIDTH-1:0] sx, zx, rd;
    logic             rf_we;
    logic [WIDTH-1:0] rf_wdata;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    assign op  = ir[WIDTH-1 -: 6];
    assign r   = ir[WIDTH-7 -: RB];
    assign imm = ir[IW-1:0];
    assign sx  = {{(WIDTH-IW){imm[IW-1]}}, imm};
    assign zx  = WIDTH'(imm);

    cpu_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
        .clk   (clk),
        .rst_b (rst_b),
        .raddr (r),
        .rdata (rd),
        .we    (rf_we),
        .waddr (r),
        .wdata (rf_wdata)
    );

    // Single-cycle ALU: AC op R[r] with carry/overflow
    always_comb begin
        sum     = {1'b0, ac} + {1'b0, rd};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (ac[WIDTH-1] == rd[WIDTH-1]) && (alu_res[WIDTH-1] != ac[WIDTH-1]);
        case (op)
            OP_SUB: begin
                alu_res = ac - rd;
                alu_c   = (ac >= rd);
                alu_v   = (ac[WIDTH-1] != rd[WIDTH-1]) && (alu_res[WIDTH-1] != ac[WIDTH-1]);
            end
            OP_AND: begin
                alu_res = ac & rd;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
            OP_OR: begin
                alu_res = ac | rd;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
            default: ;
        endcase
    end

    // Next-state, architectural updates and registered output values
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        sp_nx       = sp;
        ac_nx       = ac;
        ir_nx       = ir;
        flags_nx    = flags;
        err_nx      = err;
        address_nx  = address;
        mem_out_nx  = mem_out;
        out_data_nx = out_data;
        rf_we       = 1'b0;
        rf_wdata    = ac;

        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_nx = FETCH;
                    pc_nx    = '0;
                    sp_nx    = WIDTH'(SP_INIT);
                    flags_nx = '0;
                    err_nx   = 1'b0;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    ir_nx    = mem_in;
                    pc_nx    = pc + WIDTH'(1);
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                state_nx = FETCH;
                case (op)
                    OP_HLT:  state_nx = HALT;
                    OP_LDI:  begin rf_we = 1'b1; rf_wdata = sx; end
                    OP_LD:   begin state_nx = MEM; address_nx = zx; end
                    OP_ST:   begin state_nx = MEM; address_nx = zx; mem_out_nx = rd; end
                    OP_MOVA: ac_nx = rd;
                    OP_MOVR: begin rf_we = 1'b1; rf_wdata = ac; end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        ac_nx    = alu_res;
                        flags_nx = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
                    end
                    OP_PUSH: begin state_nx = MEM; address_nx = sp - WIDTH'(1); mem_out_nx = rd; end
                    OP_POP:  begin state_nx = MEM; address_nx = sp; end
                    OP_JMP:  pc_nx = zx;
                    OP_BZ:   if (flags[FLAG_Z]) pc_nx = zx;
                    OP_BN:   if (flags[FLAG_N]) pc_nx = zx;
                    OP_IN:   state_nx = IO_IN;
                    OP_OUT:  begin state_nx = IO_OUT; out_data_nx = rd; end
                    OP_NOP:  ;
                    default: begin state_nx = HALT; err_nx = 1'b1; end
                endcase
            end
            MEM: begin
                if (mem_ack) begin
                    state_nx = FETCH;
                    if (op == OP_LD || op == OP_POP) begin
                        rf_we    = 1'b1;
                        rf_wdata = mem_in;
                    end
                    if (op == OP_PUSH) sp_nx = sp - WIDTH'(1);
                    if (op == OP_POP)  sp_nx = sp + WIDTH'(1);
                end
            end
            IO_IN: begin
                if (inp_ack) begin
                    rf_we    = 1'b1;
                    rf_wdata = inp_data;
                    state_nx = FETCH;
                end
            end
            IO_OUT: begin
                if (out_ack) state_nx = FETCH;
            end
            default: state_nx = IDLE;
        endcase

        if (state_nx == FETCH) address_nx = pc_nx;
        finish_nx  = (state_nx == HALT);
        read_nx    = (state_nx == FETCH) || (state_nx == MEM && (op == OP_LD || op == OP_POP));
        write_nx   = (state_nx == MEM) && (op == OP_ST || op == OP_PUSH);
        inp_req_nx = (state_nx == IO_IN);
        out_req_nx = (state_nx == IO_OUT);
    end

    // State, architectural and output registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            pc       <= '0;
            sp       <= WIDTH'(SP_INIT);
            ac       <= '0;
            ir       <= '0;
            flags    <= '0;
            err      <= 1'b0;
            finish   <= 1'b0;
            read     <= 1'b0;
            write    <= 1'b0;
            inp_req  <= 1'b0;
            out_req  <= 1'b0;
            address  <= '0;
            mem_out  <= '0;
            out_data <= '0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            sp       <= sp_nx;
            ac       <= ac_nx;
            ir       <= ir_nx;
            flags    <= flags_nx;
            err      <= err_nx;
            finish   <= finish_nx;
            read     <= read_nx;
            write    <= write_nx;
            inp_req  <= inp_req_nx;
            out_req  <= out_req_nx;
            address  <= address_nx;
            mem_out  <= mem_out_nx;
            out_data <= out_data_nx;
        end
    end

endmodule

// File: tb/tb_cpu_core_param.sv
// Directed bench for cpu_core_param with wait-state memory and IO responders.
module tb_cpu_core_param;

    localparam int unsigned WIDTH = 16;

    localparam int T_HLT = 0, T_LDI = 1, T_LD = 2, T_MOVA = 4, T_ADD = 6, T_SUB = 7;
    localparam int T_PUSH = 10, T_POP = 11, T_BZ = 13, T_BN = 14, T_IN = 15, T_OUT = 16, T_NOP = 17;

    logic             clk;
    logic             rst_b;
    logic             start;
    logic             finish, err;
    logic [3:0]       flags;
    logic [WIDTH-1:0] address, mem_out, mem_in, inp_data, out_data;
    logic             read, write, mem_ack;
    logic             inp_req, inp_ack, out_req, out_ack;

    logic [WIDTH-1:0] mem [0:1023];
    int               mem_wait, in_wait, out_wait;
    int               mcnt, icnt, ocnt;
    int               rd_cycles, out_req_cycles, stab_err;
    logic [WIDTH-1:0] hold_addr, hold_out, last_waddr, last_wdata, last_out;
    logic             in_access, in_out;

    int               n_checks, n_fail;
    int               cyc;
    logic             err_at_start;

    cpu_core_param #(.WIDTH(WIDTH), .NREGS(2), .SP_INIT(512)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .start    (start),
        .finish   (finish),
        .err      (err),
        .flags    (flags),
        .address  (address),
        .mem_out  (mem_out),
        .mem_in   (mem_in),
        .read     (read),
        .write    (write),
        .mem_ack  (mem_ack),
        .inp_req  (inp_req),
        .inp_ack  (inp_ack),
        .inp_data (inp_data),
        .out_req  (out_req),
        .out_ack  (out_ack),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ack after mem_wait request cycles, checks address hold
    always @(negedge clk) begin
        if (read || write) begin
            if (in_access && address != hold_addr) stab_err++;
            hold_addr = address;
            in_access = 1'b1;
            if (read) rd_cycles++;
            mem_ack = (mcnt == mem_wait);
            if (mem_ack) begin
                if (read) begin
                    mem_in = mem[address[9:0]];
                end else begin
                    mem[address[9:0]] = mem_out;
                    last_waddr = address;
                    last_wdata = mem_out;
                end
                mcnt = 0;
                in_access = 1'b0;
            end else begin
                mem_in = 16'hDEAD;
                mcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            mem_in = 16'hDEAD;
            mcnt = 0;
            in_access = 1'b0;
        end
    end

    // IO responders: delayed acks, output data must hold while out_req is high
    always @(negedge clk) begin
        if (inp_req) begin
            inp_ack = (icnt == in_wait);
            if (inp_ack) icnt = 0; else icnt++;
        end else begin
            inp_ack = 1'b0;
            icnt = 0;
        end
        if (out_req) begin
            out_req_cycles++;
            if (in_out && out_data != hold_out) stab_err++;
            hold_out = out_data;
            in_out = 1'b1;
            out_ack = (ocnt == out_wait);
            if (out_ack) begin
                last_out = out_data;
                ocnt = 0;
                in_out = 1'b0;
            end else begin
                ocnt++;
            end
        end else begin
            out_ack = 1'b0;
            ocnt = 0;
            in_out = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int r, input int imm);
        return {6'(op), 1'(r), 9'(imm)};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    endtask

    // Pulse start for one cycle; count edges after the start edge until finish
    task automatic run_prog(input string tag, input int budget, output int cycles, output logic err0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        err0 = err;
        cycles = 0;
        while (!finish && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_done"}, 64'(finish), 64'd1);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_b = 1'b0; start = 1'b0;
        mem_wait = 0; in_wait = 0; out_wait = 0;
        mcnt = 0; icnt = 0; ocnt = 0;
        rd_cycles = 0; out_req_cycles = 0; stab_err = 0;
        in_access = 1'b0; in_out = 1'b0;
        mem_ack = 1'b0; inp_ack = 1'b0; out_ack = 1'b0;
        mem_in = 16'hDEAD; inp_data = 16'h1234;
        hold_addr = '0; hold_out = '0; last_waddr = '0; last_wdata = '0; last_out = '0;
        clear_mem();

        repeat (2) @(negedge clk);
        check("rst_ctl", 64'({finish, err, read, write, inp_req, out_req}), 64'd0);
        check("rst_bus", 64'({address, mem_out, out_data}), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ctl", 64'({finish, err, read, write, inp_req, out_req}), 64'd0);

        // Basic program, zero wait states
        mem[0] = enc(T_LDI, 0, 5);
        mem[1] = enc(T_LDI, 1, 3);
        mem[2] = enc(T_MOVA, 0, 0);
        mem[3] = enc(T_SUB, 1, 0);
        mem[4] = enc(T_HLT, 0, 0);
        run_prog("t1", 200, cyc, err_at_start);
        check("t1_cycles", 64'(cyc), 64'd10);
        check("t1_ac", 64'(dut.ac), 64'd2);
        check("t1_flags", 64'(flags), 64'b0010);
        check("t1_err", 64'(err), 64'd0);

        // Same program with 3 wait states per access
        mem_wait = 3; rd_cycles = 0; stab_err = 0;
        run_prog("t2", 200, cyc, err_at_start);
        check("t2_cycles", 64'(cyc), 64'd25);
        check("t2_ac", 64'(dut.ac), 64'd2);
        check("t2_flags", 64'(flags), 64'b0010);
        check("t2_rd_cycles", 64'(rd_cycles), 64'd20);
        check("t2_addr_hold", 64'(stab_err), 64'd0);

        // PUSH / POP round trip through the stack
        mem_wait = 0; clear_mem();
        mem[0] = enc(T_LD, 0, 100);
        mem[1] = enc(T_PUSH, 0, 0);
        mem[2] = enc(T_POP, 1, 0);
        mem[3] = enc(T_OUT, 1, 0);
        mem[4] = enc(T_HLT, 0, 0);
        mem[100] = 16'hBEEF;
        run_prog("t3", 200, cyc, err_at_start);
        check("t3_cycles", 64'(cyc), 64'd14);
        check("t3_push_addr", 64'(last_waddr), 64'd511);
        check("t3_push_data", 64'(last_wdata), 64'hBEEF);
        check("t3_pop_r1", 64'(last_out), 64'hBEEF);
        check("t3_sp", 64'(dut.sp), 64'd512);

        // Signed overflow on ADD, BN taken, BZ not taken
        clear_mem();
        mem[0]   = enc(T_LD, 0, 101);
        mem[1]   = enc(T_MOVA, 0, 0);
        mem[2]   = enc(T_LDI, 1, 1);
        mem[3]   = enc(T_ADD, 1, 0);
        mem[4]   = enc(T_BN, 0, 40);
        mem[5]   = enc(T_LDI, 1, 7);
        mem[6]   = enc(T_HLT, 0, 0);
        mem[40]  = enc(T_BZ, 0, 60);
        mem[41]  = enc(T_HLT, 0, 0);
        mem[101] = 16'h7FFF;
        run_prog("t4", 200, cyc, err_at_start);
        check("t4_cycles", 64'(cyc), 64'd15);
        check("t4_flags", 64'(flags), 64'b1001);
        check("t4_ac", 64'(dut.ac), 64'h8000);
        check("t4_pc", 64'(dut.pc), 64'd42);

        // IN/OUT with delayed acks, then zero result and BZ taken
        clear_mem();
        in_wait = 2; out_wait = 2; out_req_cycles = 0; stab_err = 0;
        mem[0]  = enc(T_IN, 1, 0);
        mem[1]  = enc(T_OUT, 1, 0);
        mem[2]  = enc(T_MOVA, 1, 0);
        mem[3]  = enc(T_SUB, 1, 0);
        mem[4]  = enc(T_BZ, 0, 50);
        mem[5]  = enc(T_HLT, 0, 0);
        mem[50] = enc(T_HLT, 0, 0);
        run_prog("t5", 200, cyc, err_at_start);
        check("t5_cycles", 64'(cyc), 64'd18);
        check("t5_out", 64'(last_out), 64'h1234);
        check("t5_out_req_cycles", 64'(out_req_cycles), 64'd3);
        check("t5_out_hold", 64'(stab_err), 64'd0);
        check("t5_flags", 64'(flags), 64'b0110);
        check("t5_pc", 64'(dut.pc), 64'd51);

        // Illegal opcode trap, then restart clears err
        in_wait = 0; out_wait = 0; clear_mem();
        mem[0] = enc(63, 0, 0);
        run_prog("t6", 50, cyc, err_at_start);
        check("t6_cycles", 64'(cyc), 64'd2);
        check("t6_err", 64'(err), 64'd1);
        mem[0] = enc(T_NOP, 0, 0);
        mem[1] = enc(T_HLT, 0, 0);
        run_prog("t6b", 50, cyc, err_at_start);
        check("t6b_err_on_start", 64'(err_at_start), 64'd0);
        check("t6b_err", 64'(err), 64'd0);
        check("t6b_cycles", 64'(cyc), 64'd4);

        // Asynchronous reset while a fetch is pending
        mem_wait = 3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t7_read_pre", 64'(read), 64'd1);
        #1 rst_b = 1'b0;
        #1;
        check("t7_read_rst", 64'(read), 64'd0);
        check("t7_addr_rst", 64'(address), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;

        // Recovery after reset
        mem_wait = 0; clear_mem();
        mem[0] = enc(T_LDI, 0, 5);
        mem[1] = enc(T_LDI, 1, 3);
        mem[2] = enc(T_MOVA, 0, 0);
        mem[3] = enc(T_SUB, 1, 0);
        mem[4] = enc(T_HLT, 0, 0);
        run_prog("t8", 200, cyc, err_at_start);
        check("t8_cycles", 64'(cyc), 64'd10);
        check("t8_ac", 64'(dut.ac), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
